// File: rtl/sr_mon_pkg.sv
// Shared types and helpers for the SR flip-flop state monitor.
package sr_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_NORMAL = 2'b01,
    ST_WARN   = 2'b10,
    ST_FAULT  = 2'b11
  } state_e;

  // Sample class is the raw {Q,QN} pair.
  typedef enum logic [1:0] {
    CLS_NONE = 2'b00,
    CLS_ZERO = 2'b01,
    CLS_ONE  = 2'b10,
    CLS_BOTH = 2'b11
  } cls_e;

  // Bits needed to hold max(thresh, recover) without overflow.
  function automatic int unsigned run_w(input int unsigned thresh, input int unsigned recover);
    int unsigned m;
    int unsigned w;
    m = (thresh > recover) ? thresh : recover;
    w = 1;
    while ((64'(1) << w) <= 64'(m)) w++;
    return w;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         CLK,
  input  logic         R,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge CLK) begin
    if (R) cnt_q <= '0;
    else   cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/sr_state_monitor.sv
// Samples an SR flip-flop's Q/QN/val, tracks valid Q, counts toggles and
// invalid samples, and debounces invalid runs into a sticky alarm.
module sr_state_monitor
  import sr_mon_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned THRESH  = 3,
  parameter int unsigned RECOVER = 2
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             CLR,
  input  logic             Q_IN,
  input  logic             QN_IN,
  input  logic             VAL_IN,
  output logic             Q_OUT,
  output logic [1:0]       STATE,
  output logic             ALARM,
  output logic             CONSIST_ERR,
  output logic [CNT_W-1:0] TOGGLE_CNT,
  output logic [CNT_W-1:0] FAULT_CNT
);

  localparam int unsigned RUN_W = run_w(THRESH, RECOVER);

  state_e             state_q, state_d;
  logic [RUN_W-1:0]   bad_q, bad_d, good_q, good_d;
  logic [RUN_W-1:0]   bad_nxt, good_nxt;
  logic               q_out_q, q_out_d;
  logic               alarm_q, alarm_d;
  logic               consist_q, consist_d;
  logic               tog_inc, flt_inc;
  cls_e               cls;
  logic               valid;

  assign cls      = cls_e'({Q_IN, QN_IN});
  assign valid    = VAL_IN && ((cls == CLS_ONE) || (cls == CLS_ZERO));
  assign bad_nxt  = bad_q + RUN_W'(1);
  assign good_nxt = good_q + RUN_W'(1);

  // Next-state, run tracking and counter strobes.
  always_comb begin
    state_d   = state_q;
    bad_d     = bad_q;
    good_d    = good_q;
    q_out_d   = q_out_q;
    tog_inc   = 1'b0;
    flt_inc   = 1'b0;
    consist_d = VAL_IN != (Q_IN ^ QN_IN);

    if (CLR) begin
      state_d = ST_IDLE;
      bad_d   = '0;
      good_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_NORMAL: begin
          if (valid) begin
            state_d = ST_NORMAL;
            q_out_d = Q_IN;
            tog_inc = (state_q == ST_NORMAL) && (Q_IN != q_out_q);
          end else begin
            flt_inc = 1'b1;
            bad_d   = RUN_W'(1);
            good_d  = '0;
            state_d = (THRESH == 1) ? ST_FAULT : ST_WARN;
          end
        end
        ST_WARN: begin
          if (valid) begin
            q_out_d = Q_IN;
            tog_inc = Q_IN != q_out_q;
            bad_d   = '0;
            if (good_nxt == RUN_W'(RECOVER)) begin
              state_d = ST_NORMAL;
              good_d  = '0;
            end else begin
              good_d  = good_nxt;
            end
          end else begin
            flt_inc = 1'b1;
            good_d  = '0;
            bad_d   = bad_nxt;
            if (bad_nxt == RUN_W'(THRESH)) state_d = ST_FAULT;
          end
        end
        ST_FAULT: ;
        default: state_d = ST_IDLE;
      endcase
    end

    alarm_d = state_d == ST_FAULT;
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      state_q   <= ST_IDLE;
      bad_q     <= '0;
      good_q    <= '0;
      q_out_q   <= 1'b0;
      alarm_q   <= 1'b0;
      consist_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bad_q     <= bad_d;
      good_q    <= good_d;
      q_out_q   <= q_out_d;
      alarm_q   <= alarm_d;
      consist_q <= consist_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_toggle_cnt (
    .CLK (CLK),
    .R   (R),
    .inc (tog_inc),
    .q   (TOGGLE_CNT)
  );

  sat_counter #(.W(CNT_W)) u_fault_cnt (
    .CLK (CLK),
    .R   (R),
    .inc (flt_inc),
    .q   (FAULT_CNT)
  );

  assign Q_OUT       = q_out_q;
  assign STATE       = state_q;
  assign ALARM       = alarm_q;
  assign CONSIST_ERR = consist_q;

endmodule

// File: tb/tb_sr_state_monitor.sv
// Bench for sr_state_monitor: directed vector table, hand sequence, and
// randomized run against a behavioural model (default and CNT_W=2 instances).
module tb_sr_state_monitor;

  logic CLK, R, CLR, Q_IN, QN_IN, VAL_IN;

  logic       q_out_a, alarm_a, cerr_a;
  logic [1:0] state_a;
  logic [7:0] tog_a, flt_a;

  logic       q_out_b, alarm_b, cerr_b;
  logic [1:0] state_b;
  logic [1:0] tog_b, flt_b;

  int total = 0;
  int bad   = 0;

  sr_state_monitor dut (
    .CLK(CLK), .R(R), .CLR(CLR), .Q_IN(Q_IN), .QN_IN(QN_IN), .VAL_IN(VAL_IN),
    .Q_OUT(q_out_a), .STATE(state_a), .ALARM(alarm_a), .CONSIST_ERR(cerr_a),
    .TOGGLE_CNT(tog_a), .FAULT_CNT(flt_a)
  );

  sr_state_monitor #(.CNT_W(2)) dut2 (
    .CLK(CLK), .R(R), .CLR(CLR), .Q_IN(Q_IN), .QN_IN(QN_IN), .VAL_IN(VAL_IN),
    .Q_OUT(q_out_b), .STATE(state_b), .ALARM(alarm_b), .CONSIST_ERR(cerr_b),
    .TOGGLE_CNT(tog_b), .FAULT_CNT(flt_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int r, clr, q, qn, v;
    int st, qo, al, ce, tg, tg2, ft, ft2;
  } vec_t;

  vec_t tbl [23];

  // Behavioural model state (plain integers, unbounded counts).
  int m_st, m_qo, m_ce, m_tog, m_flt, m_bad, m_good;
  localparam int M_THRESH = 3, M_RECOVER = 2;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int r, input int clr, input int q, input int qn, input int v);
    R = 1'(r); CLR = 1'(clr); Q_IN = 1'(q); QN_IN = 1'(qn); VAL_IN = 1'(v);
    @(posedge CLK);
    #1;
  endtask

  function automatic int sat(input int x, input int lim);
    return (x > lim) ? lim : x;
  endfunction

  task automatic model_step(input int r, input int clr, input int q, input int qn, input int v);
    bit ok;
    if (r != 0) begin
      m_st = 0; m_qo = 0; m_ce = 0; m_tog = 0; m_flt = 0; m_bad = 0; m_good = 0;
      return;
    end
    m_ce = (v != (q ^ qn)) ? 1 : 0;
    if (clr != 0) begin
      m_st = 0; m_bad = 0; m_good = 0;
      return;
    end
    if (m_st == 3) return;
    ok = (q != qn) && (v != 0);
    if (!ok) begin
      m_flt++;
      m_bad  = (m_st == 2) ? m_bad + 1 : 1;
      m_good = 0;
      m_st   = (m_bad >= M_THRESH) ? 3 : 2;
    end else begin
      if (m_st != 0 && q != m_qo) m_tog++;
      m_qo = q;
      if (m_st == 0) m_st = 1;
      else if (m_st == 2) begin
        m_bad = 0;
        m_good++;
        if (m_good == M_RECOVER) begin
          m_st = 1; m_good = 0;
        end
      end
    end
  endtask

  initial begin
    R = 1'b1; CLR = 1'b0; Q_IN = 1'b0; QN_IN = 1'b0; VAL_IN = 1'b0;

    //           r clr q qn v   st qo al ce tg tg2 ft ft2
    tbl[0]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 1,  1, 1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 1, 1,  1, 0, 0, 0, 1, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 1, 1,  1, 0, 0, 0, 1, 1, 0, 0};
    tbl[4]  = '{0, 0, 1, 0, 1,  1, 1, 0, 0, 2, 2, 0, 0};
    tbl[5]  = '{0, 0, 1, 1, 0,  2, 1, 0, 0, 2, 2, 1, 1};
    tbl[6]  = '{0, 0, 0, 0, 0,  2, 1, 0, 0, 2, 2, 2, 2};
    tbl[7]  = '{0, 0, 1, 1, 0,  3, 1, 1, 0, 2, 2, 3, 3};
    tbl[8]  = '{0, 0, 1, 0, 1,  3, 1, 1, 0, 2, 2, 3, 3};
    tbl[9]  = '{0, 0, 1, 1, 1,  3, 1, 1, 1, 2, 2, 3, 3};
    tbl[10] = '{0, 1, 0, 1, 1,  0, 1, 0, 0, 2, 2, 3, 3};
    tbl[11] = '{0, 0, 0, 1, 1,  1, 0, 0, 0, 2, 2, 3, 3};
    tbl[12] = '{0, 0, 1, 1, 0,  2, 0, 0, 0, 2, 2, 4, 3};
    tbl[13] = '{0, 0, 0, 1, 1,  2, 0, 0, 0, 2, 2, 4, 3};
    tbl[14] = '{0, 0, 1, 0, 1,  1, 1, 0, 0, 3, 3, 4, 3};
    tbl[15] = '{0, 0, 1, 0, 0,  2, 1, 0, 1, 3, 3, 5, 3};
    tbl[16] = '{1, 1, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0};
    tbl[17] = '{0, 0, 1, 0, 1,  1, 1, 0, 0, 0, 0, 0, 0};
    tbl[18] = '{0, 0, 0, 1, 1,  1, 0, 0, 0, 1, 1, 0, 0};
    tbl[19] = '{0, 0, 1, 0, 1,  1, 1, 0, 0, 2, 2, 0, 0};
    tbl[20] = '{0, 0, 0, 1, 1,  1, 0, 0, 0, 3, 3, 0, 0};
    tbl[21] = '{0, 0, 1, 0, 1,  1, 1, 0, 0, 4, 3, 0, 0};
    tbl[22] = '{0, 0, 0, 1, 1,  1, 0, 0, 0, 5, 3, 0, 0};

    for (int i = 0; i < 23; i++) begin
      cyc(tbl[i].r, tbl[i].clr, tbl[i].q, tbl[i].qn, tbl[i].v);
      chk($sformatf("vec%0d.state", i), int'(state_a), tbl[i].st);
      chk($sformatf("vec%0d.q_out", i), int'(q_out_a), tbl[i].qo);
      chk($sformatf("vec%0d.alarm", i), int'(alarm_a), tbl[i].al);
      chk($sformatf("vec%0d.consist", i), int'(cerr_a), tbl[i].ce);
      chk($sformatf("vec%0d.toggle", i), int'(tog_a), tbl[i].tg);
      chk($sformatf("vec%0d.fault", i), int'(flt_a), tbl[i].ft);
      chk($sformatf("vec%0d.toggle_w2", i), int'(tog_b), tbl[i].tg2);
      chk($sformatf("vec%0d.fault_w2", i), int'(flt_b), tbl[i].ft2);
    end

    // Reset while sitting in FAULT: nothing counted on the reset edge.
    cyc(0, 0, 0, 0, 0);
    chk("seq.warn1", int'(state_a), 2);
    cyc(0, 0, 0, 0, 0);
    chk("seq.warn2", int'(state_a), 2);
    cyc(0, 0, 0, 0, 0);
    chk("seq.fault", int'(state_a), 3);
    chk("seq.alarm", int'(alarm_a), 1);
    chk("seq.fault_cnt", int'(flt_a), 3);
    cyc(1, 0, 1, 1, 0);
    chk("seq.rst_state", int'(state_a), 0);
    chk("seq.rst_alarm", int'(alarm_a), 0);
    chk("seq.rst_fault_cnt", int'(flt_a), 0);
    chk("seq.rst_toggle", int'(tog_a), 5 - 5);
    chk("seq.rst_consist", int'(cerr_a), 0);

    // Randomized run against the behavioural model.
    model_step(1, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      int r, c, q, qn, v;
      r  = ($urandom_range(0, 99) == 0) ? 1 : 0;
      c  = ($urandom_range(0, 39) == 0) ? 1 : 0;
      q  = int'($urandom_range(0, 1));
      qn = ($urandom_range(0, 3) == 0) ? q : 1 - q;
      v  = ($urandom_range(0, 7) == 0) ? 1 - (q ^ qn) : (q ^ qn);
      cyc(r, c, q, qn, v);
      model_step(r, c, q, qn, v);
      chk("rnd.state", int'(state_a), m_st);
      chk("rnd.q_out", int'(q_out_a), m_qo);
      chk("rnd.alarm", int'(alarm_a), (m_st == 3) ? 1 : 0);
      chk("rnd.consist", int'(cerr_a), m_ce);
      chk("rnd.toggle", int'(tog_a), sat(m_tog, 255));
      chk("rnd.fault", int'(flt_a), sat(m_flt, 255));
      chk("rnd.toggle_w2", int'(tog_b), sat(m_tog, 3));
      chk("rnd.fault_w2", int'(flt_b), sat(m_flt, 3));
      chk("rnd.state_w2", int'(state_b), m_st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
